// File: rtl/crc8_frame_gen.sv
`timescale 1ns/1ps
// crc8_frame_gen
//   Serialises a DATA_BYTES-byte payload LSB-first and appends the
//   Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00) as the
//   final 8 bits. The completed frame is also presented in parallel
//   as {crc, payload}. A frame produced here checks to a zero residue
//   in the matching CRC checker.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   F1M        bit-rate enable tick; state advances only on ticked edges
//   start      frame request, sampled while idle
//   data_in    payload, byte k in bits [8k+7:8k]
//   bit_ready  downstream accepts bit_out
//   bit_valid  bit_out holds a valid frame bit
//   bit_out    current serial bit (LSB of byte 0 first)
//   busy       frame in progress
//   done       one-clk pulse after the last CRC bit is accepted
//   crc_out    CRC of the last completed frame
//   frame_out  {crc_out, payload} of the last completed frame
module crc8_frame_gen #(
  parameter int DATA_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      F1M,
  input  logic                      start,
  input  logic [DATA_BYTES*8-1:0]   data_in,
  input  logic                      bit_ready,
  output logic                      bit_valid,
  output logic                      bit_out,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                crc_out,
  output logic [DATA_BYTES*8+7:0]   frame_out
);

  localparam int PAY_W = DATA_BYTES * 8;
  localparam int CNT_W = $clog2(PAY_W);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t             state;
  logic [PAY_W-1:0]   shift;
  logic [PAY_W-1:0]   payload;
  logic [7:0]         crc;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         crc_nxt;
  logic               last_data;
  logic               last_crc;

  // One step of the reflected CRC-8: shift right, fold feedback into bits 7,3,2.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic m;
    m = b ^ c[0];
    return {m, c[7:5], m ^ c[4], m ^ c[3], c[2:1]};
  endfunction

  assign crc_nxt   = crc_step(crc, shift[0]);
  assign last_data = (cnt == CNT_W'(PAY_W - 1));
  assign last_crc  = (cnt == CNT_W'(7));

  // Shift register drains to zero by the end of a frame, so bit_out rests low.
  assign bit_out = shift[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      payload   <= '0;
      crc       <= '0;
      cnt       <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_out   <= '0;
      frame_out <= '0;
    end else begin
      // done is a single-clk pulse, independent of the bit-rate tick
      done <= 1'b0;
      if (F1M) begin
        case (state)
          IDLE: begin
            if (start) begin
              shift     <= data_in;
              payload   <= data_in;
              crc       <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              bit_valid <= 1'b1;
              state     <= DATA;
            end
          end
          DATA: begin
            if (bit_ready) begin
              crc <= crc_nxt;
              if (last_data) begin
                // all payload bits are gone; the low byte now carries the CRC
                shift <= PAY_W'(crc_nxt);
                cnt   <= '0;
                state <= CRC;
              end else begin
                shift <= shift >> 1;
                cnt   <= cnt + CNT_W'(1);
              end
            end
          end
          CRC: begin
            if (bit_ready) begin
              shift <= shift >> 1;
              if (last_crc) begin
                crc_out   <= crc;
                frame_out <= {crc, payload};
                done      <= 1'b1;
                busy      <= 1'b0;
                bit_valid <= 1'b0;
                cnt       <= '0;
                state     <= IDLE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_gen.sv
`timescale 1ns/1ps
module tb_crc8_frame_gen;

  localparam int NB = 7;
  localparam int PW = NB * 8;

  logic            clk;
  logic            rst;
  logic            f1m;
  logic            start;
  logic [PW-1:0]   data_in;
  logic            bit_ready;
  logic            bit_valid;
  logic            bit_out;
  logic            busy;
  logic            done;
  logic [7:0]      crc_out;
  logic [PW+7:0]   frame_out;

  int nchk  = 0;
  int nfail = 0;

  crc8_frame_gen #(.DATA_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .F1M       (f1m),
    .start     (start),
    .data_in   (data_in),
    .bit_ready (bit_ready),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .busy      (busy),
    .done      (done),
    .crc_out   (crc_out),
    .frame_out (frame_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Maxim CRC-8, byte at a time, LSB-first within each byte.
  function automatic logic [7:0] ref_crc(input logic [PW-1:0] d);
    logic [7:0] c;
    logic [7:0] b;
    logic       mix;
    c = 8'h00;
    for (int k = 0; k < NB; k++) begin
      b = d[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        mix = c[0] ^ b[0];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
        b   = b >> 1;
      end
    end
    return c;
  endfunction

  // Runs one frame; exp_crc is either hand-computed or taken from ref_crc.
  task automatic run_frame(input logic [PW-1:0] d, input logic [7:0] exp_crc,
                           input int stall_pct, input bit mid_start,
                           input bit start_at_end, input string tag);
    logic [PW+7:0] exp_frame;
    logic [PW+7:0] stream;
    int            nbits;
    int            cyc;
    bit            got_done;
    bit            stable_ok;
    bit            busy_ok;
    bit            prev_stall;
    logic          prev_bit;
    bit            xfer;
    exp_frame  = {exp_crc, d};
    stream     = '0;
    nbits      = 0;
    cyc        = 0;
    got_done   = 1'b0;
    stable_ok  = 1'b1;
    busy_ok    = 1'b1;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;

    @(negedge clk);
    data_in   = d;
    start     = 1'b1;
    f1m       = 1'b1;
    bit_ready = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~d;  // must not disturb the latched frame
    chk({tag, "_busy_on_start"}, 128'(busy), 128'(1));

    while (!got_done && cyc < 4000) begin
      if (prev_stall && bit_valid && (bit_out !== prev_bit)) stable_ok = 1'b0;
      if (bit_valid && !busy) busy_ok = 1'b0;
      f1m       = ($urandom_range(99) >= stall_pct);
      bit_ready = ($urandom_range(99) >= stall_pct);
      start     = (mid_start && nbits >= 20 && nbits < 24) ||
                  (start_at_end && nbits == PW + 7);
      xfer = bit_valid && f1m && bit_ready;
      if (xfer) begin
        if (nbits < PW + 8) stream[nbits] = bit_out;
        nbits++;
      end
      prev_stall = !xfer;
      prev_bit   = bit_out;
      @(negedge clk);
      cyc++;
      if (done) got_done = 1'b1;
    end

    chk({tag, "_done_seen"}, 128'(got_done), 128'(1));
    chk({tag, "_nbits"}, 128'(nbits), 128'(PW + 8));
    chk({tag, "_stream"}, 128'(stream), 128'(exp_frame));
    chk({tag, "_crc_out"}, 128'(crc_out), 128'(exp_crc));
    chk({tag, "_frame_out"}, 128'(frame_out), 128'(exp_frame));
    chk({tag, "_stable"}, 128'(stable_ok), 128'(1));
    chk({tag, "_busy_held"}, 128'(busy_ok), 128'(1));
    // start held on the completing edge must not have launched a new frame
    chk({tag, "_idle_at_done"}, 128'({busy, bit_valid}), 128'(0));
    start = 1'b0;
    f1m   = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_clk"}, 128'(done), 128'(0));
  endtask

  initial begin
    logic [63:0]   r;
    logic [PW-1:0] d;
    int            nd;

    rst       = 1'b1;
    f1m       = 1'b0;
    start     = 1'b0;
    bit_ready = 1'b0;
    data_in   = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        128'({bit_valid, bit_out, busy, done, crc_out, frame_out}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Classic ROM-code example: 02 1C B8 01 00 00 00 -> CRC A2
    run_frame(56'h00000001B81C02, 8'hA2, 0, 1'b0, 1'b0, "rom");
    chk("rom_frame_literal", 128'(frame_out), 128'(64'hA200000001B81C02));

    run_frame('0, 8'h00, 0, 1'b0, 1'b0, "zero");
    run_frame(56'h01, ref_crc(56'h01), 0, 1'b0, 1'b0, "one");
    run_frame(56'hFFFFFFFFFFFFFF, ref_crc(56'hFFFFFFFFFFFFFF), 40, 1'b0, 1'b0, "ones_stall");
    run_frame(56'h0123456789ABCD, ref_crc(56'h0123456789ABCD), 20, 1'b1, 1'b0, "mid_start");
    run_frame(56'hA5A55A5AC3C33C, ref_crc(56'hA5A55A5AC3C33C), 0, 1'b0, 1'b1, "start_at_end");

    // Abort a frame after 30 transferred bits.
    @(negedge clk);
    data_in   = 56'hDEADBEEF123456;
    start     = 1'b1;
    f1m       = 1'b1;
    bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs",
        128'({bit_valid, bit_out, busy, done, crc_out, frame_out}), 128'(0));
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 128'(nd), 128'(0));
    run_frame(56'h00000001B81C02, 8'hA2, 0, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 300; i++) begin
      r = {$urandom(), $urandom()};
      d = r[PW-1:0];
      run_frame(d, ref_crc(d), 30, 1'b0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
